// File: rtl/rail_sequencer_if.sv
// rail_sequencer_if: command/status bundle between the rail sequencer and the rail monitors.
// Revision: 1.0
`default_nettype none

interface rail_sequencer_if #(
  parameter int N_RAILS = 4
);
  logic               i_powerReq;
  logic [N_RAILS-1:0] i_railGood;
  logic [N_RAILS-1:0] i_railFault;
  logic [N_RAILS-1:0] o_railEnable;
  logic               o_allGood;
  logic               o_fault;
  logic [3:0]         o_faultRail;
  logic               o_timeout;
  logic [1:0]         o_retryCount;

  modport master (
    input  i_powerReq, i_railGood, i_railFault,
    output o_railEnable, o_allGood, o_fault, o_faultRail, o_timeout, o_retryCount
  );

  modport slave (
    output i_powerReq, i_railGood, i_railFault,
    input  o_railEnable, o_allGood, o_fault, o_faultRail, o_timeout, o_retryCount
  );
endinterface

`default_nettype wire

// File: rtl/rail_sequencer.sv
// rail_sequencer: ordered power-up / reverse power-down of N regulator rails with fault shutdown.
// Optional auto-retry from FAULT under macro POWER_SEQ_AUTO_RETRY_EN. Revision: 1.0
`default_nettype none

module rail_sequencer #(
  parameter int N_RAILS      = 4,
  parameter int CNT_W        = 23,
  parameter int TIMEOUT      = 100000,
  parameter int SETTLE_DELAY = 1000,
  parameter int DOWN_DELAY   = 1000,
  parameter int MAX_RETRIES  = 3,
  parameter int RETRY_DELAY  = 100000
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  rail_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_SETTLE    = 3'd2,
    S_ON        = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  // A zero delay parameter behaves as a one-cycle delay.
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(((TIMEOUT      == 0) ? 1 : TIMEOUT)      - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LAST  = CNT_W'(((SETTLE_DELAY == 0) ? 1 : SETTLE_DELAY) - 1);
  localparam logic [CNT_W-1:0] c_DOWN_LAST    = CNT_W'(((DOWN_DELAY   == 0) ? 1 : DOWN_DELAY)   - 1);
  localparam logic [3:0]       c_LAST_IDX     = 4'(N_RAILS - 1);

  state_t             r_state;
  logic [3:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_RAILS-1:0] r_railEnable;
  logic               r_allGood;
  logic               r_fault;
  logic [3:0]         r_faultRail;
  logic               r_timeout;

  logic [N_RAILS-1:0] w_faultVec;
  logic               w_faultAny;
  logic [3:0]         w_faultIdx;
  logic [N_RAILS-1:0] w_idxMask;
  logic               w_idxGood;

  assign w_faultVec = bus.i_railFault & r_railEnable;
  assign w_faultAny = |w_faultVec;
  assign w_idxMask  = N_RAILS'(1) << r_idx;
  assign w_idxGood  = |(bus.i_railGood & w_idxMask);

  always_comb begin
    w_faultIdx = 4'd0;
    for (int k = N_RAILS - 1; k >= 0; k--) begin
      if (w_faultVec[k]) w_faultIdx = 4'(k);
    end
  end

`ifdef POWER_SEQ_AUTO_RETRY_EN
  localparam logic [CNT_W-1:0] c_RETRY_LAST = CNT_W'(((RETRY_DELAY == 0) ? 1 : RETRY_DELAY) - 1);
  logic [1:0] r_retryCount;
  assign bus.o_retryCount = r_retryCount;
`else
  localparam int c_unused_retry = MAX_RETRIES + RETRY_DELAY;
  assign bus.o_retryCount = 2'd0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 4'd0;
      r_cnt        <= '0;
      r_railEnable <= '0;
      r_allGood    <= 1'b0;
      r_fault      <= 1'b0;
      r_faultRail  <= 4'd0;
      r_timeout    <= 1'b0;
`ifdef POWER_SEQ_AUTO_RETRY_EN
      r_retryCount <= 2'd0;
`endif
    end else if (w_faultAny) begin
      // Enables are all zero in IDLE and FAULT, so this only fires in the four active states.
      r_state      <= S_FAULT;
      r_railEnable <= '0;
      r_allGood    <= 1'b0;
      r_fault      <= 1'b1;
      r_faultRail  <= w_faultIdx;
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_powerReq) begin
            r_state      <= S_RAMP_UP;
            r_idx        <= 4'd0;
            r_cnt        <= '0;
            r_railEnable <= N_RAILS'(1);
            r_faultRail  <= 4'd0;
            r_timeout    <= 1'b0;
          end
        end
        S_RAMP_UP: begin
          if (!w_idxGood && r_cnt == c_TIMEOUT_LAST) begin
            r_state      <= S_FAULT;
            r_railEnable <= '0;
            r_fault      <= 1'b1;
            r_faultRail  <= r_idx;
            r_timeout    <= 1'b1;
            r_cnt        <= '0;
          end else if (!bus.i_powerReq) begin
            r_state      <= S_RAMP_DOWN;
            r_railEnable <= r_railEnable & ~w_idxMask;
            r_cnt        <= '0;
          end else if (w_idxGood) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (!bus.i_powerReq) begin
            r_state      <= S_RAMP_DOWN;
            r_railEnable <= r_railEnable & ~w_idxMask;
            r_cnt        <= '0;
          end else if (r_cnt == c_SETTLE_LAST) begin
            r_cnt <= '0;
            if (r_idx == c_LAST_IDX) begin
              r_state   <= S_ON;
              r_allGood <= 1'b1;
`ifdef POWER_SEQ_AUTO_RETRY_EN
              r_retryCount <= 2'd0;
`endif
            end else begin
              r_state      <= S_RAMP_UP;
              r_idx        <= r_idx + 4'd1;
              r_railEnable <= r_railEnable | (w_idxMask << 1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ON: begin
          if (!bus.i_powerReq) begin
            r_state      <= S_RAMP_DOWN;
            r_idx        <= c_LAST_IDX;
            r_railEnable <= r_railEnable & ~(N_RAILS'(1) << c_LAST_IDX);
            r_allGood    <= 1'b0;
            r_cnt        <= '0;
          end
        end
        S_RAMP_DOWN: begin
          if (r_cnt == c_DOWN_LAST) begin
            r_cnt <= '0;
            if (r_idx == 4'd0) begin
              r_state <= S_IDLE;
            end else begin
              r_idx        <= r_idx - 4'd1;
              r_railEnable <= r_railEnable & ~(w_idxMask >> 1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FAULT: begin
`ifdef POWER_SEQ_AUTO_RETRY_EN
          if (!bus.i_powerReq) begin
            r_state      <= S_IDLE;
            r_fault      <= 1'b0;
            r_retryCount <= 2'd0;
            r_cnt        <= '0;
          end else if (r_cnt == c_RETRY_LAST) begin
            // Once retries are exhausted the count parks here until the request drops.
            if (32'(r_retryCount) < MAX_RETRIES) begin
              r_retryCount <= r_retryCount + 2'd1;
              r_state      <= S_RAMP_UP;
              r_idx        <= 4'd0;
              r_cnt        <= '0;
              r_railEnable <= N_RAILS'(1);
              r_fault      <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`else
          if (!bus.i_powerReq) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
            r_cnt   <= '0;
          end
`endif
        end
        default: begin
          r_state      <= S_IDLE;
          r_railEnable <= '0;
        end
      endcase
    end
  end

  assign bus.o_railEnable = r_railEnable;
  assign bus.o_allGood    = r_allGood;
  assign bus.o_fault      = r_fault;
  assign bus.o_faultRail  = r_faultRail;
  assign bus.o_timeout    = r_timeout;

endmodule

`default_nettype wire
